// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: forwards HPS download bytes to the core with region decode,
// validates length/order, and holds the core in reset until a good image has settled.
module rom_load_ctrl #(
    parameter int AW          = 17,
    parameter int TOTAL       = 'h1_0000,
    parameter int R0_END      = 'h0_4000,
    parameter int R1_END      = 'h0_8000,
    parameter int R2_END      = 'h0_C000,
    parameter int HOLD_CYCLES = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          dn_wr,
    output logic [AW-1:0] dn_addr,
    output logic [7:0]    dn_dout,
    output logic [3:0]    dn_region,
    output logic          core_reset,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   byte_count,
    output logic [15:0]   checksum,
    output logic [1:0]    dbg_state   // 0 IDLE, 1 LOAD, 2 HOLD, 3 RUN
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic [AW:0]   TOTAL_C   = (AW+1)'(TOTAL);
    localparam logic [AW-1:0] R0_C      = AW'(R0_END);
    localparam logic [AW-1:0] R1_C      = AW'(R1_END);
    localparam logic [AW-1:0] R2_C      = AW'(R2_END);
    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_dn_wr;
    logic [AW-1:0] r_dn_addr;
    logic [7:0]    r_dn_dout;
    logic [3:0]    r_dn_region;
    logic          r_core_reset;
    logic          r_load_done;
    logic          r_load_err;
    logic [AW:0]   r_byte_count;
    logic [15:0]   r_checksum;
    logic [HW-1:0] r_hold_cnt;

    logic          w_rom_ev;
    logic          w_wr_ev;
    logic          w_in_range;
    logic          w_start;
    logic          w_accept;
    logic          w_in_order;
    logic [AW:0]   w_cnt_base;
    logic [15:0]   w_sum_base;
    logic          w_err_base;
    logic          w_err_nxt;
    logic          w_exit_err;
    logic          w_hold_clr;
    logic          w_hold_inc;
    logic [3:0]    w_region;

    // Any non-LOAD state re-enters LOAD on a ROM event, so the status clear and the
    // first byte of the new image land on the same edge.
    assign w_rom_ev   = ioctl_download && (ioctl_index == 8'd0);
    assign w_wr_ev    = w_rom_ev && ioctl_wr;
    assign w_in_range = {1'b0, ioctl_addr} < TOTAL_C;
    assign w_start    = w_rom_ev && (r_state != S_LOAD);
    assign w_accept   = w_wr_ev && w_in_range;
    assign w_cnt_base = w_start ? '0 : r_byte_count;
    assign w_sum_base = w_start ? 16'd0 : r_checksum;
    assign w_err_base = w_start ? 1'b0 : r_load_err;
    assign w_in_order = {1'b0, ioctl_addr} == w_cnt_base;
    assign w_err_nxt  = w_err_base | (w_wr_ev && !w_in_range) | (w_accept && !w_in_order) | w_exit_err;

    always_comb begin
        w_region = 4'b1000;
        if (ioctl_addr < R0_C) begin
            w_region = 4'b0001;
        end else if (ioctl_addr < R1_C) begin
            w_region = 4'b0010;
        end else if (ioctl_addr < R2_C) begin
            w_region = 4'b0100;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exit_err  = 1'b0;
        w_hold_clr  = 1'b0;
        w_hold_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rom_ev) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (!w_rom_ev) begin
                    if ((r_byte_count == TOTAL_C) && !r_load_err) begin
                        w_state_nxt = S_HOLD;
                        w_hold_clr  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_exit_err  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_rom_ev) begin
                    w_state_nxt = S_LOAD;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_hold_inc = 1'b1;
                end
            end
            S_RUN: begin
                if (w_rom_ev) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dn_wr      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_dout    <= 8'd0;
            r_dn_region  <= 4'b0001;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_byte_count <= '0;
            r_checksum   <= 16'd0;
            r_hold_cnt   <= '0;
        end else begin
            r_dn_wr <= w_accept;
            if (w_accept) begin
                r_dn_addr    <= ioctl_addr;
                r_dn_dout    <= ioctl_dout;
                r_dn_region  <= w_region;
                r_byte_count <= w_cnt_base + (AW+1)'(1);
                r_checksum   <= w_sum_base + {8'd0, ioctl_dout};
            end else if (w_start) begin
                r_byte_count <= '0;
                r_checksum   <= 16'd0;
            end
            r_load_err <= w_err_nxt;
            if (w_hold_clr) begin
                r_hold_cnt <= '0;
            end else if (w_hold_inc) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
            // Registered from next state so both flags switch on the state-change edge.
            r_core_reset <= (w_state_nxt != S_RUN);
            r_load_done  <= (w_state_nxt == S_RUN);
        end
    end

    assign dn_wr      = r_dn_wr;
    assign dn_addr    = r_dn_addr;
    assign dn_dout    = r_dn_dout;
    assign dn_region  = r_dn_region;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign byte_count = r_byte_count;
    assign checksum   = r_checksum;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: randomized ROM loads checked against a transaction-level model.
module tb_rom_load_ctrl;

  localparam int AW   = 17;
  localparam int TOT  = 16;
  localparam int HOLD = 4;
  localparam int W    = 32 + AW + 8 + 4;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk_sys) cyc <= cyc + 32'd1;

  // main DUT (small image)
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index    = 8'd0;
  logic          ioctl_wr       = 1'b0;
  logic [AW-1:0] ioctl_addr     = '0;
  logic [7:0]    ioctl_dout     = 8'd0;
  logic          dn_wr;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_dout;
  logic [3:0]    dn_region;
  logic          core_reset, load_done, load_err;
  logic [AW:0]   byte_count;
  logic [15:0]   checksum;
  logic [1:0]    dbg_state;

  rom_load_ctrl #(.AW(AW), .TOTAL(TOT), .HOLD_CYCLES(HOLD)) u_dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_dout(dn_dout), .dn_region(dn_region),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err),
    .byte_count(byte_count), .checksum(checksum), .dbg_state(dbg_state)
  );

  // default-parameter DUT for region decode
  logic          d_download = 1'b0;
  logic [7:0]    d_index    = 8'd0;
  logic          d_wr       = 1'b0;
  logic [AW-1:0] d_addr     = '0;
  logic [7:0]    d_dout     = 8'd0;
  logic          d_dn_wr;
  logic [AW-1:0] d_dn_addr;
  logic [7:0]    d_dn_dout;
  logic [3:0]    d_dn_region;
  logic          d_core_reset, d_load_done, d_load_err;
  logic [AW:0]   d_byte_count;
  logic [15:0]   d_checksum;
  logic [1:0]    d_dbg_state;

  rom_load_ctrl u_def (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(d_download), .ioctl_index(d_index), .ioctl_wr(d_wr),
    .ioctl_addr(d_addr), .ioctl_dout(d_dout),
    .dn_wr(d_dn_wr), .dn_addr(d_dn_addr), .dn_dout(d_dn_dout), .dn_region(d_dn_region),
    .core_reset(d_core_reset), .load_done(d_load_done), .load_err(d_load_err),
    .byte_count(d_byte_count), .checksum(d_checksum), .dbg_state(d_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state: what the block should report for the current load.
  int m_count = 0;
  int m_sum   = 0;
  bit m_err   = 1'b0;

  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) act_q.push_back({cyc, dn_addr, dn_dout, dn_region});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] region_of(input int a);
    if (a < 'h4000) return 4'b0001;
    if (a < 'h8000) return 4'b0010;
    if (a < 'hC000) return 4'b0100;
    return 4'b1000;
  endfunction

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) chk(tag, 64'(act_q[i]), 64'(exp_q[i]));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_load_done"},  64'(load_done),  64'd0);
    chk({tag, "_load_err"},   64'(load_err),   64'd0);
    chk({tag, "_dn_wr"},      64'(dn_wr),      64'd0);
    chk({tag, "_dn_addr"},    64'(dn_addr),    64'd0);
    chk({tag, "_dn_dout"},    64'(dn_dout),    64'd0);
    chk({tag, "_dn_region"},  64'(dn_region),  64'b0001);
    chk({tag, "_byte_count"}, 64'(byte_count), 64'd0);
    chk({tag, "_checksum"},   64'(checksum),   64'd0);
    chk({tag, "_state_idle"}, 64'(dbg_state),  64'd0);
  endtask

  // ---------------- driver tasks (called on a negedge, return on a negedge) -------
  task automatic start_rom();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    m_count = 0;
    m_sum   = 0;
    m_err   = 1'b0;
  endtask

  task automatic drive_byte(input int a, input logic [7:0] d);
    logic [31:0] st;
    st = cyc + 32'd1;
    ioctl_wr   = 1'b1;
    ioctl_addr = AW'(a);
    ioctl_dout = d;
    if (ioctl_download && ioctl_index == 8'd0) begin
      if (a < TOT) begin
        if (a != m_count) m_err = 1'b1;
        m_count = m_count + 1;
        m_sum   = (m_sum + int'(d)) % 65536;
        exp_q.push_back({st, AW'(a), d, region_of(a)});
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic end_load();
    ioctl_download = 1'b0;
    if (!(m_count == TOT && !m_err)) m_err = 1'b1;
  endtask

  task automatic random_good(input bit gaps);
    for (int i = 0; i < TOT; i++) begin
      drive_byte(i, 8'($urandom_range(0, 255)));
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end
  endtask

  // bounded wait: core must come out of reset exactly HOLD+1 edges after download drops
  task automatic expect_release(input string tag);
    int n;
    n = 0;
    while (n < HOLD + 10) begin
      @(negedge clk_sys);
      n = n + 1;
      if (core_reset === 1'b0) break;
    end
    chk({tag, "_release_edges"}, 64'(n), 64'(HOLD + 1));
    chk({tag, "_load_done"},     64'(load_done), 64'd1);
    chk({tag, "_load_err"},      64'(load_err),  64'(m_err));
    chk({tag, "_byte_count"},    64'(byte_count), 64'(m_count));
    chk({tag, "_checksum"},      64'(checksum),   64'(m_sum));
  endtask

  task automatic expect_held(input string tag);
    repeat (HOLD + 3) @(negedge clk_sys);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_load_done"},  64'(load_done),  64'd0);
    chk({tag, "_load_err"},   64'(load_err),   64'(m_err));
    chk({tag, "_byte_count"}, 64'(byte_count), 64'(m_count));
    chk({tag, "_checksum"},   64'(checksum),   64'(m_sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] r_addrs [4];
    logic [3:0]    r_exp   [4];
    int            p;
    logic [15:0]   keep_sum;

    r_addrs[0] = 17'h03FFF; r_exp[0] = 4'b0001;
    r_addrs[1] = 17'h04000; r_exp[1] = 4'b0010;
    r_addrs[2] = 17'h0BFFF; r_exp[2] = 4'b0100;
    r_addrs[3] = 17'h0C000; r_exp[3] = 4'b1000;

    repeat (3) @(negedge clk_sys);
    check_reset_vals("in_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_reset_vals("after_reset");

    // good load with fixed data 0x01..0x10, back-to-back
    start_rom();
    for (int i = 0; i < TOT; i++) drive_byte(i, 8'(i + 1));
    end_load();
    expect_release("good");
    chk("good_checksum_const", 64'(checksum), 64'h0088);
    check_stream("good_stream");

    // index 1 download while running is ignored
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    for (int i = 0; i < 3; i++) drive_byte(i, 8'($urandom_range(0, 255)));
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    repeat (2) @(negedge clk_sys);
    chk("ign_core_reset", 64'(core_reset), 64'd0);
    chk("ign_load_done",  64'(load_done),  64'd1);
    chk("ign_byte_count", 64'(byte_count), 64'(TOT));
    chk("ign_checksum",   64'(checksum),   64'h0088);
    check_stream("ign_stream");

    // reload from RUN
    start_rom();
    @(negedge clk_sys);
    chk("reload_core_reset", 64'(core_reset), 64'd1);
    chk("reload_load_done",  64'(load_done),  64'd0);
    chk("reload_state_load", 64'(dbg_state),  64'd1);
    random_good(1'b1);
    end_load();
    expect_release("reload");
    check_stream("reload_stream");

    // short load
    start_rom();
    for (int i = 0; i < TOT - 1; i++) drive_byte(i, 8'($urandom_range(0, 255)));
    end_load();
    @(negedge clk_sys);
    chk("short_state_idle", 64'(dbg_state), 64'd0);
    expect_held("short");
    check_stream("short_stream");

    // out-of-range address after a full image
    start_rom();
    random_good(1'b0);
    drive_byte(TOT, 8'($urandom_range(0, 255)));
    chk("oor_err_now", 64'(load_err), 64'd1);
    end_load();
    expect_held("oor");
    check_stream("oor_stream");

    // out-of-order: one random adjacent pair swapped
    p = $urandom_range(1, TOT - 2);
    start_rom();
    for (int i = 0; i < TOT; i++) begin
      int a;
      a = (i == p) ? p + 1 : (i == p + 1) ? p : i;
      drive_byte(a, 8'($urandom_range(0, 255)));
    end
    end_load();
    expect_held("ooo");
    check_stream("ooo_stream");

    // new ROM event during HOLD restarts the load
    start_rom();
    random_good(1'b0);
    end_load();
    repeat (2) @(negedge clk_sys);
    chk("hold_core_reset", 64'(core_reset), 64'd1);
    start_rom();
    @(negedge clk_sys);
    chk("hold_restart_state", 64'(dbg_state),  64'd1);
    chk("hold_restart_count", 64'(byte_count), 64'd0);
    random_good(1'b1);
    end_load();
    expect_release("hold_restart");
    check_stream("hold_restart_stream");

    // asynchronous reset mid-load
    start_rom();
    for (int i = 0; i < 8; i++) drive_byte(i, 8'($urandom_range(0, 255)));
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    check_stream("mid_reset_stream");
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    start_rom();
    random_good(1'b1);
    keep_sum = 16'(m_sum);
    end_load();
    expect_release("post_reset");
    chk("post_reset_sum_new_only", 64'(checksum), 64'(keep_sum));
    check_stream("post_reset_stream");

    // region decode on default-parameter instance
    d_download = 1'b1;
    d_index    = 8'd0;
    for (int i = 0; i < 4; i++) begin
      d_wr   = 1'b1;
      d_addr = r_addrs[i];
      d_dout = 8'($urandom_range(0, 255));
      @(negedge clk_sys);
      d_wr = 1'b0;
      chk("region_dn_wr",   64'(d_dn_wr),     64'd1);
      chk("region_dn_addr", 64'(d_dn_addr),   64'(r_addrs[i]));
      chk("region_decode",  64'(d_dn_region), 64'(r_exp[i]));
    end
    d_download = 1'b0;
    @(negedge clk_sys);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
